hack_data_memory: RTL and testbench

Data-memory responder for the Hack CPU. Answers the CPU's data-side bus (address, write data, write strobe) with a combinational read word. Implements the standard Hack map: 16K RAM, 8K-word screen buffer, one keyboard register. Also provides a registered read port for the display scan-out engine and a valid/ready ingress for keyboard codes.

---
 rtl/hack_memory_pkg.sv | 36 +++
 rtl/hack_screen_ram.sv | 66 ++++++
 rtl/hack_data_memory.sv | 122 ++++++++++++
 tb/tb_hack_data_memory.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_memory_pkg.sv
// Shared definitions for the Hack data-memory block.
// Purpose : address/data widths, fixed map constants, the decode-region enum
//           and the address decoder used by hack_data_memory.
// Ports   : none (package).
package hack_memory_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] SCREEN_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR    = 15'h6000;

  typedef enum logic [1:0] {
    REGION_RAM      = 2'd0,
    REGION_SCREEN   = 2'd1,
    REGION_KBD      = 2'd2,
    REGION_UNMAPPED = 2'd3
  } region_e;

  // Top two address bits select the region. 00/01 are both RAM (16K words),
  // 10 is the screen, and in 11 only the single keyboard word is mapped.
  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    region_e r;
    if (addr[14] == 1'b0) begin
      r = REGION_RAM;
    end else if (addr[14:13] == SCREEN_BASE[14:13]) begin
      r = REGION_SCREEN;
    end else if (addr == KBD_ADDR) begin
      r = REGION_KBD;
    end else begin
      r = REGION_UNMAPPED;
    end
    return r;
  endfunction

endpackage

// File: rtl/hack_screen_ram.sv
// Dual-port screen buffer.
// Purpose : WORDS x 16 store. Port A (CPU) has an asynchronous read and a
//           synchronous write. Port B (display) has a registered read with a
//           write-first bypass when port A writes the same word on that edge.
// Ports   : clk_i, rst_ni        clock, async active-low reset (port B regs)
//           a_addr_i/a_wdata_i/a_we_i/a_rdata_o   CPU port
//           b_req_i/b_addr_i/b_data_o/b_valid_o   display port
module hack_screen_ram
  import hack_memory_pkg::*;
#(
  parameter int WORDS = 8192,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IDX_W-1:0]  a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  input  logic              a_we_i,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic [IDX_W-1:0]  b_addr_i,
  output logic [DATA_W-1:0] b_data_o,
  output logic              b_valid_o
);

  logic [DATA_W-1:0] mem [WORDS];
  logic [DATA_W-1:0] b_data_q, b_data_d;
  logic              b_valid_q, b_valid_d;

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (a_we_i) begin
      mem[a_addr_i] <= a_wdata_i;
    end
  end

  assign a_rdata_o = mem[a_addr_i];

  // Write-first: a same-edge CPU write to the requested word is returned
  // instead of the stale stored value.
  always_comb begin
    b_valid_d = b_req_i;
    b_data_d  = b_data_q;
    if (b_req_i) begin
      if (a_we_i && (a_addr_i == b_addr_i)) begin
        b_data_d = a_wdata_i;
      end else begin
        b_data_d = mem[b_addr_i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_data_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
    end
  end

  assign b_data_o  = b_data_q;
  assign b_valid_o = b_valid_q;

endmodule

// File: rtl/hack_data_memory.sv
// Hack CPU data-memory responder.
// Purpose : standard Hack map -- 16K RAM at 0x0000, screen buffer at 0x4000,
//           keyboard register at 0x6000 -- with a combinational CPU read,
//           a registered display read port, a keyboard ingress and a sticky
//           unmapped-access flag.
// Ports   : clock, reset (async, active-low)
//           address/in/load -> out         CPU data bus (combinational read)
//           kbd_code/kbd_valid -> kbd_ready keyboard ingress
//           scr_req/scr_addr -> scr_data/scr_valid  display port, 1-cycle
//           bad_access                     sticky unmapped-access flag
//
// Keyboard handshake: a code transfers on a rising edge where kbd_valid and
// kbd_ready are both 1. kbd_ready is 1 whenever reset is deasserted, so the
// block never back-pressures; the producer may change kbd_code freely while
// kbd_valid is 0.
module hack_data_memory
  import hack_memory_pkg::*;
#(
  parameter int RAM_WORDS    = 16384,
  parameter int SCREEN_WORDS = 8192
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  input  logic              load,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] kbd_code,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  input  logic              scr_req,
  input  logic [12:0]       scr_addr,
  output logic [DATA_W-1:0] scr_data,
  output logic              scr_valid,
  output logic              bad_access
);

  localparam int RAM_IDX_W = $clog2(RAM_WORDS);
  localparam int SCR_IDX_W = $clog2(SCREEN_WORDS);

  region_e region;
  assign region = decode_region(address);

  logic [RAM_IDX_W-1:0] ram_idx;
  logic [SCR_IDX_W-1:0] scr_cpu_idx;
  assign ram_idx     = address[RAM_IDX_W-1:0];
  assign scr_cpu_idx = address[SCR_IDX_W-1:0];

  // Writes are gated by reset so an edge seen while reset is low never
  // modifies the un-reset storage.
  logic ram_we, scr_we;
  assign ram_we = load && reset && (region == REGION_RAM);
  assign scr_we = load && reset && (region == REGION_SCREEN);

  // ---------------- RAM (inline, not reset) ----------------
  logic [DATA_W-1:0] ram_mem [RAM_WORDS];
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram_mem[ram_idx] <= in;
    end
  end

  // ---------------- Screen buffer ----------------
  logic [DATA_W-1:0] scr_cpu_rdata;
  hack_screen_ram #(
    .WORDS (SCREEN_WORDS)
  ) u_screen (
    .clk_i     (clock),
    .rst_ni    (reset),
    .a_addr_i  (scr_cpu_idx),
    .a_wdata_i (in),
    .a_we_i    (scr_we),
    .a_rdata_o (scr_cpu_rdata),
    .b_req_i   (scr_req),
    .b_addr_i  (scr_addr[SCR_IDX_W-1:0]),
    .b_data_o  (scr_data),
    .b_valid_o (scr_valid)
  );

  // ---------------- Keyboard register and sticky flag ----------------
  logic [DATA_W-1:0] kbd_q, kbd_d;
  logic              bad_access_q, bad_access_d;

  assign kbd_ready = reset;

  always_comb begin
    kbd_d        = kbd_q;
    bad_access_d = bad_access_q;
    if (kbd_valid && kbd_ready) begin
      kbd_d = kbd_code;
    end
    // A cycle without load is a CPU read; reads are ignored while the
    // display port is requesting so one access is not counted twice.
    if ((region == REGION_UNMAPPED) && (load || !scr_req)) begin
      bad_access_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      kbd_q        <= '0;
      bad_access_q <= 1'b0;
    end else begin
      kbd_q        <= kbd_d;
      bad_access_q <= bad_access_d;
    end
  end

  assign bad_access = bad_access_q;

  // ---------------- CPU read mux ----------------
  always_comb begin
    out = '0;
    case (region)
      REGION_RAM:    out = ram_mem[ram_idx];
      REGION_SCREEN: out = scr_cpu_rdata;
      REGION_KBD:    out = kbd_q;
      default:       out = '0;
    endcase
  end

endmodule

// File: tb/tb_hack_data_memory.sv
// Bench for hack_data_memory: directed vectors, expected values pushed into
// queues by the stimulus, popped and compared by a negedge monitor.
module tb_hack_data_memory;

  logic        clock;
  logic        reset;
  logic [14:0] address;
  logic [15:0] wdata;
  logic        load;
  logic [15:0] out;
  logic [15:0] kbd_code;
  logic        kbd_valid;
  logic        kbd_ready;
  logic        scr_req;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        bad_access;

  logic        cpu_chk;

  logic [15:0] scr_exp_q[$];
  string       scr_name_q[$];
  logic [15:0] cpu_exp_q[$];
  string       cpu_name_q[$];

  int checks = 0;
  int errors = 0;

  hack_data_memory dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .in         (wdata),
    .load       (load),
    .out        (out),
    .kbd_code   (kbd_code),
    .kbd_valid  (kbd_valid),
    .kbd_ready  (kbd_ready),
    .scr_req    (scr_req),
    .scr_addr   (scr_addr),
    .scr_data   (scr_data),
    .scr_valid  (scr_valid),
    .bad_access (bad_access)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (scr_valid) begin
      if (scr_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scr_unexpected: got scr_valid=1 data %h expected no response", scr_data);
      end else begin
        check(scr_name_q.pop_front(), scr_data, scr_exp_q.pop_front());
      end
    end
    if (cpu_chk) begin
      if (cpu_exp_q.size() != 0) begin
        check(cpu_name_q.pop_front(), out, cpu_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [14:0] a, input logic [15:0] d);
    address = a;
    wdata   = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
    address = '0;
  endtask

  task automatic cpu_read(input logic [14:0] a, input logic [15:0] e, input string name);
    address = a;
    cpu_exp_q.push_back(e);
    cpu_name_q.push_back(name);
    cpu_chk = 1'b1;
    step();
    cpu_chk = 1'b0;
    address = '0;
  endtask

  task automatic scr_issue(input logic [12:0] idx, input logic [15:0] e, input string name);
    scr_req  = 1'b1;
    scr_addr = idx;
    scr_exp_q.push_back(e);
    scr_name_q.push_back(name);
  endtask

  task automatic kbd_send(input logic [15:0] code);
    kbd_code  = code;
    kbd_valid = 1'b1;
    step();
    kbd_valid = 1'b0;
    kbd_code  = 16'hFFFF;  // ignored without valid
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    address   = '0;
    wdata     = '0;
    load      = 1'b0;
    kbd_code  = '0;
    kbd_valid = 1'b0;
    scr_req   = 1'b0;
    scr_addr  = '0;
    cpu_chk   = 1'b0;

    repeat (2) step();
    check("rst_scr_valid", {15'd0, scr_valid}, 16'd0);
    check("rst_scr_data", scr_data, 16'h0000);
    check("rst_bad_access", {15'd0, bad_access}, 16'd0);
    check("rst_kbd_ready", {15'd0, kbd_ready}, 16'd0);
    cpu_read(15'h6000, 16'h0000, "rst_kbd_reg");

    reset = 1'b1;
    #1;
    check("kbd_ready_up", {15'd0, kbd_ready}, 16'd1);
    step();

    // RAM
    cpu_write(15'h0005, 16'h1234);
    cpu_write(15'h3FFF, 16'hA5A5);
    cpu_write(15'h2000, 16'h0F0F);
    cpu_write(15'h3000, 16'h3030);
    cpu_read(15'h0005, 16'h1234, "ram_0005");
    cpu_read(15'h3FFF, 16'hA5A5, "ram_3fff");
    cpu_read(15'h2000, 16'h0F0F, "ram_2000");

    // Screen via CPU port
    cpu_write(15'h4003, 16'h3333);
    cpu_write(15'h5000, 16'h5555);
    cpu_write(15'h4000, 16'h1000);
    cpu_write(15'h4001, 16'h1001);
    cpu_write(15'h4002, 16'h1002);
    cpu_read(15'h4003, 16'h3333, "scr_cpu_4003");
    cpu_read(15'h5000, 16'h5555, "scr_cpu_5000");

    // Collision: write-first
    address = 15'h4010;
    wdata   = 16'hBEEF;
    load    = 1'b1;
    scr_issue(13'h0010, 16'hBEEF, "scr_collision");
    step();
    load    = 1'b0;
    scr_req = 1'b0;
    address = '0;
    cpu_read(15'h4010, 16'hBEEF, "scr_cpu_4010");

    // Back-to-back display reads
    scr_issue(13'd0, 16'h1000, "scr_b2b_0");
    step();
    scr_issue(13'd1, 16'h1001, "scr_b2b_1");
    step();
    scr_issue(13'd2, 16'h1002, "scr_b2b_2");
    step();
    scr_req = 1'b0;
    step();
    check("scr_valid_idle", {15'd0, scr_valid}, 16'd0);
    check("scr_data_hold", scr_data, 16'h1002);

    // Keyboard
    kbd_send(16'h0041);
    cpu_read(15'h6000, 16'h0041, "kbd_accept");
    cpu_write(15'h6000, 16'hFFFF);
    cpu_read(15'h6000, 16'h0041, "kbd_write_dropped");
    cpu_read(15'h6000, 16'h0041, "kbd_no_valid_hold");
    kbd_send(16'h0000);
    cpu_read(15'h6000, 16'h0000, "kbd_release");
    kbd_send(16'h0041);

    // Unmapped: read while the display is requesting is not counted
    scr_issue(13'd0, 16'h1000, "scr_during_unmapped");
    cpu_read(15'h6001, 16'h0000, "unmapped_read");
    scr_req = 1'b0;
    #1;
    check("bad_access_not_yet", {15'd0, bad_access}, 16'd0);
    cpu_write(15'h7000, 16'hDEAD);
    check("bad_access_set", {15'd0, bad_access}, 16'd1);
    cpu_read(15'h3000, 16'h3030, "unmapped_no_ram_alias");
    cpu_read(15'h5000, 16'h5555, "unmapped_no_scr_alias");
    cpu_read(15'h0005, 16'h1234, "ram_after_unmapped");
    check("bad_access_sticky", {15'd0, bad_access}, 16'd1);

    // Reset mid-stream with a screen response in flight
    scr_issue(13'd0, 16'h1000, "scr_pre_reset");
    step();
    scr_addr = 13'd1;  // response to this request is discarded by reset
    @(posedge clock);
    #2;
    reset   = 1'b0;
    scr_req = 1'b0;
    #1;
    check("midrst_scr_valid", {15'd0, scr_valid}, 16'd0);
    check("midrst_scr_data", scr_data, 16'h0000);
    check("midrst_bad_access", {15'd0, bad_access}, 16'd0);
    check("midrst_kbd_ready", {15'd0, kbd_ready}, 16'd0);
    address = 15'h6000;
    #1;
    check("midrst_kbd_reg", out, 16'h0000);
    // A write across an edge while reset is low must be ignored
    address = 15'h0005;
    wdata   = 16'hFFFF;
    load    = 1'b1;
    step();
    reset   = 1'b1;
    load    = 1'b0;
    address = '0;
    step();
    cpu_read(15'h0005, 16'h1234, "ram_after_reset");
    cpu_read(15'h4010, 16'hBEEF, "scr_after_reset");
    check("bad_access_after_reset", {15'd0, bad_access}, 16'd0);

    // Drain: every queued expectation must have been consumed
    for (int i = 0; i < 10; i++) begin
      if (scr_exp_q.size() == 0 && cpu_exp_q.size() == 0) break;
      step();
    end
    checks++;
    if (scr_exp_q.size() != 0 || cpu_exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d scr and %0d cpu pending expected 0", scr_exp_q.size(), cpu_exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
